// File: rtl/i2osp_ctrl.sv
// i2osp_ctrl -- Integer-to-Octet-String Primitive (I2OSP) controller.
//
// Converts a non-negative integer x into a big-endian octet string of x_len
// bytes. The octets are streamed one per handshake, most significant first,
// with zero padding ahead of the significant bytes. The request is rejected
// with err when x does not fit in x_len bytes, or when x_len exceeds the
// register width.
//
// Ports:
//   clk        single clock, rising edge
//   reset      synchronous active-high reset
//   start      conversion request, sampled only while idle
//   x          integer to convert, sampled with start
//   x_len      requested octet-string length in bytes, sampled with start
//   busy       high whenever the controller is not idle
//   out_byte   current octet, most significant first
//   out_valid  out_byte is valid
//   out_ready  consumer accepts out_byte
//   out_last   high with out_valid on the final octet
//   done       one-cycle completion pulse
//   err        one-cycle rejection pulse, coincident with done
module i2osp_ctrl #(
    parameter int DATA_BIT_WIDTH = 2048
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [DATA_BIT_WIDTH-1:0] x,
    input  logic [8:0]                x_len,
    output logic                      busy,
    output logic [7:0]                out_byte,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last,
    output logic                      done,
    output logic                      err
);

    localparam int NBYTES = DATA_BIT_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, CHECK, STREAM, FIN} state_t;

    state_t                    state;
    logic [DATA_BIT_WIDTH-1:0] sreg;
    logic [8:0]                cnt;
    logic                      err_flag;

    logic [31:0] len32;
    logic [31:0] lo_shift;
    logic [31:0] pad_shift;
    logic        too_long;
    logic        hi_nonzero;
    logic        check_err;

    // Range check on the latched request. Any bit at or above byte x_len
    // means the integer does not fit; pad_shift moves octet x_len-1 to the
    // top of the register so streaming always reads the same byte lane.
    always_comb begin
        len32      = {23'd0, cnt};
        lo_shift   = len32 << 3;
        pad_shift  = (len32 < 32'(NBYTES)) ? ((32'(NBYTES) - len32) << 3) : 32'd0;
        too_long   = len32 > 32'(NBYTES);
        hi_nonzero = (len32 < 32'(NBYTES)) && ((sreg >> lo_shift) != '0);
        check_err  = too_long || hi_nonzero;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            sreg      <= '0;
            cnt       <= '0;
            err_flag  <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sreg     <= x;
                        cnt      <= x_len;
                        err_flag <= 1'b0;
                        state    <= CHECK;
                    end
                end
                CHECK: begin
                    if (check_err) begin
                        err_flag <= 1'b1;
                        done     <= 1'b1;
                        state    <= FIN;
                    end else if (cnt == 9'd0) begin
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        sreg  <= sreg << pad_shift;
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    // First STREAM cycle raises out_valid; the aligned
                    // octet is already sitting in the top byte lane.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        sreg <= sreg << 8;
                        cnt  <= cnt - 9'd1;
                        if (cnt == 9'd1) begin
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= FIN;
                        end
                    end
                end
                FIN: begin
                    done     <= 1'b0;
                    err_flag <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy     = (state != IDLE);
    assign out_byte = sreg[DATA_BIT_WIDTH-1 -: 8];
    assign out_last = out_valid && (cnt == 9'd1);
    assign err      = done && err_flag;

endmodule

// File: tb/tb_i2osp_ctrl.sv
// tb_i2osp_ctrl -- directed bench for i2osp_ctrl (default 2048-bit width).
// Expected octets are queued when a request is issued and popped as the DUT
// hands them over.
module tb_i2osp_ctrl;

    localparam int W = 2048;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] x;
    logic [8:0]   x_len;
    logic         busy;
    logic [7:0]   out_byte;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic         done;
    logic         err;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    i2osp_ctrl #(.DATA_BIT_WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .x        (x),
        .x_len    (x_len),
        .busy     (busy),
        .out_byte (out_byte),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // mode 0: out_ready always 1; mode 1: out_ready toggles, low first.
    // poke_k >= 0 pulses start with a different x at that cycle.
    // rst_hs >= 0 asserts reset right after that many handshakes.
    task automatic xfer(input logic [W-1:0] xv, input int len, input int mode,
                        input bit exp_err, input int poke_k, input int rst_hs);
        int         k;
        int         hs;
        int         vcnt;
        int         b;
        int         exp_v;
        logic [7:0] held;
        bit         stalled;
        bit         got_done;
        if (!exp_err) begin
            for (int i = 0; i < len; i++) begin
                b = len - 1 - i;
                exp_q.push_back((b < W / 8) ? xv[8*b +: 8] : 8'h00);
            end
        end
        x         = xv;
        x_len     = 9'(len);
        start     = 1'b1;
        out_ready = 1'b1;
        tick();
        start    = 1'b0;
        k        = 0;
        hs       = 0;
        vcnt     = 0;
        held     = 8'h00;
        stalled  = 1'b0;
        got_done = 1'b0;
        while (k < 4 * len + 20 && !got_done) begin
            start = (k == poke_k);
            if (k == poke_k) begin
                x     = ~xv;
                x_len = 9'd1;
            end
            out_ready = (mode == 1) ? (k % 2 == 1) : 1'b1;
            @(negedge clk);
            if (stalled) begin
                chk("stall_byte", 32'(out_byte), 32'(held));
                chk("stall_valid", 32'(out_valid), 32'd1);
                stalled = 1'b0;
            end
            if (out_valid) begin
                vcnt++;
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_octet", 32'(out_byte), 32'hFFFF_FFFF);
                    end else begin
                        chk("octet", 32'(out_byte), 32'(exp_q.pop_front()));
                        chk("last", 32'(out_last), 32'(exp_q.size() == 0));
                    end
                    hs++;
                end else begin
                    held    = out_byte;
                    stalled = 1'b1;
                end
            end
            if (done) begin
                got_done = 1'b1;
                chk("err", 32'(err), 32'(exp_err));
                chk("left_octets", 32'(exp_q.size()), 32'd0);
                exp_v = (exp_err || len == 0) ? 0 : ((mode == 1) ? 2 * len : len);
                chk("valid_cycles", 32'(vcnt), 32'(exp_v));
                if (mode == 0)
                    chk("latency", 32'(k), 32'((exp_err || len == 0) ? 1 : len + 2));
            end
            tick();
            k++;
            if (hs == rst_hs) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                @(negedge clk);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_valid", 32'(out_valid), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                chk("rst_byte", 32'(out_byte), 32'd0);
                exp_q.delete();
                return;
            end
        end
        if (!got_done) chk("done_timeout", 32'd0, 32'd1);
        start = 1'b0;
        @(negedge clk);
        chk("idle_after", 32'(busy), 32'd0);
        chk("done_pulse", 32'(done), 32'd0);
    endtask

    initial begin
        logic [W-1:0] v;
        reset     = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        x         = '0;
        x_len     = 9'd0;
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_last", 32'(out_last), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_byte", 32'(out_byte), 32'd0);

        // Zero-padded short integer.
        v = '0; v[15:0] = 16'h0102;
        xfer(v, 4, 0, 1'b0, -1, -1);

        // Integer too large for requested length.
        v = '0; v[16] = 1'b1;
        xfer(v, 2, 0, 1'b1, -1, -1);

        // Empty strings and over-length request.
        v = '0;
        xfer(v, 0, 0, 1'b0, -1, -1);
        v = '0; v[0] = 1'b1;
        xfer(v, 0, 0, 1'b1, -1, -1);
        v = '0; v[7:0] = 8'h05;
        xfer(v, 257, 0, 1'b1, -1, -1);

        // Exact fit versus one bit over.
        v = '0; v[23:0] = 24'h80_0000;
        xfer(v, 3, 0, 1'b0, -1, -1);
        v = '0; v[24] = 1'b1;
        xfer(v, 3, 0, 1'b1, -1, -1);

        // Full width with backpressure every other cycle.
        v = '1;
        xfer(v, 256, 1, 1'b0, -1, -1);

        // Reset mid-stream, then a single-octet transfer.
        v = '0; v[127:0] = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
        xfer(v, 16, 0, 1'b0, -1, 3);
        v = '0; v[7:0] = 8'hAB;
        xfer(v, 1, 0, 1'b0, -1, -1);

        // start while busy is ignored.
        v = '0; v[23:0] = 24'h11_2233;
        xfer(v, 3, 0, 1'b0, 3, -1);

        // Distinct byte pattern with full-width alignment.
        v = '0; v[39:0] = 40'hDE_AD_BE_EF_5A;
        xfer(v, 8, 1, 1'b0, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
